// File: rtl/account_txn_ctrl.sv
// Account transaction engine: reads one record from the account RAM, applies a
// query/withdraw/deposit against it, writes the record back on success, then answers.
module account_txn_ctrl #(
    parameter int FINAL_UP_LIMIT_WIDTH   = 15,
    parameter int AVAILABLE_CREDIT_WIDTH = 25,
    parameter int RAM_DATA_WIDTH         = FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH,
    parameter int RAM_MEM_SIZE           = 64,
    localparam int AW                    = $clog2(RAM_MEM_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [1:0]                        req_op,
    input  logic [AW-1:0]                     req_addr,
    input  logic [AVAILABLE_CREDIT_WIDTH-1:0] req_amount,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [1:0]                        rsp_status,
    output logic [AVAILABLE_CREDIT_WIDTH-1:0] rsp_credit,
    output logic [FINAL_UP_LIMIT_WIDTH-1:0]   rsp_limit,
    output logic                              ram_we,
    output logic [AW-1:0]                     ram_addr,
    output logic [RAM_DATA_WIDTH-1:0]         ram_wdata,
    input  logic [RAM_DATA_WIDTH-1:0]         ram_rdata
);

    localparam int LW = FINAL_UP_LIMIT_WIDTH;
    localparam int CW = AVAILABLE_CREDIT_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;

    localparam logic [1:0] OP_QUERY    = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NO_CREDIT = 2'b01;
    localparam logic [1:0] ST_LIMIT     = 2'b10;
    localparam logic [1:0] ST_OVF_BAD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   amount_q, amount_d;
    logic [DW-1:0]   record_q, record_d;
    logic [1:0]      status_q, status_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [LW-1:0]   limit_q, limit_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    // Evaluation of the captured record
    logic [LW-1:0]   rec_limit;
    logic [CW-1:0]   rec_credit;
    logic [CW:0]     dep_sum;
    logic [1:0]      exec_status;
    logic [CW-1:0]   exec_credit;
    logic            exec_write;

    assign rec_limit  = record_q[DW-1 -: LW];
    assign rec_credit = record_q[CW-1:0];
    assign dep_sum    = {1'b0, rec_credit} + {1'b0, amount_q};

    always_comb begin
        exec_status = ST_OK;
        exec_credit = rec_credit;
        exec_write  = 1'b0;
        case (op_q)
            OP_QUERY: begin
                exec_status = ST_OK;
            end
            OP_WITHDRAW: begin
                // Compare at record width so neither field is truncated
                if (DW'(amount_q) > DW'(rec_limit)) begin
                    exec_status = ST_LIMIT;
                end else if (amount_q > rec_credit) begin
                    exec_status = ST_NO_CREDIT;
                end else begin
                    exec_credit = rec_credit - amount_q;
                    exec_write  = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (dep_sum[CW]) begin
                    exec_status = ST_OVF_BAD;
                end else begin
                    exec_credit = dep_sum[CW-1:0];
                    exec_write  = 1'b1;
                end
            end
            default: begin
                exec_status = ST_OVF_BAD;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        amount_d = amount_q;
        record_d = record_q;
        status_d = status_q;
        credit_d = credit_q;
        limit_d  = limit_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    addr_d   = req_addr;
                    amount_d = req_amount;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                record_d = ram_rdata;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                status_d = exec_status;
                credit_d = exec_credit;
                limit_d  = rec_limit;
                if (exec_write) begin
                    wdata_d = {rec_limit, exec_credit};
                    state_d = S_WRITE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            amount_q <= '0;
            record_q <= '0;
            status_q <= '0;
            credit_q <= '0;
            limit_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            amount_q <= amount_d;
            record_q <= record_d;
            status_q <= status_d;
            credit_q <= credit_d;
            limit_q  <= limit_d;
            wdata_q  <= wdata_d;
        end
    end

    // Handshake strobes come straight off the state register
    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign ram_we     = (state_q == S_WRITE);
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign rsp_status = status_q;
    assign rsp_credit = credit_q;
    assign rsp_limit  = limit_q;

endmodule
